// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between two valid/ready requesters.
// The sum is registered into a single-entry response slot tagged with the
// owning requester ID and the carry-out.

`ifndef WORD
`define WORD 32
`endif

// Shared combinational adder datapath.
module adder #(
  parameter int WORD = `WORD
) (
  input  logic [WORD-1:0] Ain,
  input  logic [WORD-1:0] Bin,
  output logic [WORD-1:0] add_out
);

  // Plain modular sum; the carry is recovered by the caller.
  assign add_out = Ain + Bin;

endmodule

module adder_arbiter #(
  parameter int WORD = `WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [WORD-1:0] req0_a,
  input  logic [WORD-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [WORD-1:0] req1_a,
  input  logic [WORD-1:0] req1_b,
  output logic            req1_ready,
  output logic            rsp_valid,
  output logic [WORD-1:0] rsp_data,
  output logic            rsp_id,
  output logic            rsp_carry,
  input  logic            rsp_ready,
  output logic            busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_reg;
  logic            prio_reg;
  logic            rsp_valid_reg;
  logic [WORD-1:0] rsp_data_reg;
  logic            rsp_id_reg;
  logic            rsp_carry_reg;

  logic            can_accept;
  logic            both_valid;
  logic            grant0;
  logic            grant1;
  logic            grant_any;
  logic [WORD-1:0] ain;
  logic [WORD-1:0] bin;
  logic [WORD-1:0] sum;
  logic            carry;

  // The slot is free when empty, or when the held result leaves this cycle,
  // which lets a new add land every cycle.
  assign can_accept = (state_reg == EMPTY) | (rsp_ready & rsp_valid_reg);
  assign both_valid = req0_valid & req1_valid;

  // Grant: a lone requester always wins; a tie goes to the priority pointer.
  // Gated by rst_n so no handshake can be signalled while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && can_accept) begin
      if (both_valid) begin
        grant0 = ~prio_reg;
        grant1 = prio_reg;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign grant_any  = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux defaults to requester 0 when nothing is granted; the result
  // is then simply not captured.
  assign ain = grant1 ? req1_a : req0_a;
  assign bin = grant1 ? req1_b : req0_b;

  adder #(.WORD(WORD)) u_adder (
    .Ain     (ain),
    .Bin     (bin),
    .add_out (sum)
  );

  // An unsigned sum smaller than an operand means the addition wrapped.
  assign carry = (sum < ain);

  // Response slot FSM: capture on grant, drain on consumer accept, and
  // rotate priority only after a contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      prio_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= 1'b0;
      rsp_carry_reg <= 1'b0;
    end else begin
      if (grant_any) begin
        state_reg     <= FULL;
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= sum;
        rsp_carry_reg <= carry;
        rsp_id_reg    <= grant1;
        if (both_valid) begin
          prio_reg <= grant0;
        end
      end else if ((state_reg == FULL) && rsp_ready) begin
        state_reg     <= EMPTY;
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_carry = rsp_carry_reg;
  assign busy      = rsp_valid_reg & ~rsp_ready;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: stimulus pushes hand-computed
// responses, a negedge monitor pops them on every response handshake.

module tb_adder_arbiter;

  localparam int WORD = 32;

  logic            clk;
  logic            rst_n;
  logic            req0_valid;
  logic [WORD-1:0] req0_a;
  logic [WORD-1:0] req0_b;
  logic            req0_ready;
  logic            req1_valid;
  logic [WORD-1:0] req1_a;
  logic [WORD-1:0] req1_b;
  logic            req1_ready;
  logic            rsp_valid;
  logic [WORD-1:0] rsp_data;
  logic            rsp_id;
  logic            rsp_carry;
  logic            rsp_ready;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;

  // {id, data, carry}
  logic [WORD+1:0] sb[$];

  adder_arbiter #(.WORD(WORD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_carry  (rsp_carry),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [WORD-1:0] a0, input logic [WORD-1:0] b0,
                       input logic v1, input logic [WORD-1:0] a1, input logic [WORD-1:0] b1,
                       input logic rr);
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    rsp_ready  = rr;
  endtask

  // One clock: check readys and rsp_valid mid-cycle, queue the expected
  // response for an expected grant, then step past the rising edge.
  task automatic tick(input logic e0, input logic e1, input logic erv,
                      input logic [WORD-1:0] ed, input logic ec);
    @(negedge clk);
    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    if (e0 || e1) sb.push_back({e1, ed, ec});
    @(posedge clk);
    #1;
  endtask

  // Back-pressured cycle: result must stay put and nobody gets a grant.
  task automatic hold(input logic [WORD-1:0] ed, input logic eid);
    @(negedge clk);
    chk("hold_valid", 64'(rsp_valid), 64'd1);
    chk("hold_data", 64'(rsp_data), 64'(ed));
    chk("hold_id", 64'(rsp_id), 64'(eid));
    chk("hold_busy", 64'(busy), 64'd1);
    chk("hold_ready0", 64'(req0_ready), 64'd0);
    chk("hold_ready1", 64'(req1_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response is compared with the queue head.
  always @(negedge clk) begin
    logic [WORD+1:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      $display("rsp %0d: id=%0d data=%0h carry=%0d", n_rsp, rsp_id, rsp_data, rsp_carry);
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e[WORD+1]));
        chk("rsp_data", 64'(rsp_data), 64'(e[WORD:1]));
        chk("rsp_carry", 64'(rsp_carry), 64'(e[0]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'd2, 32'd10, 1'b0, 32'd0, 32'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Single requester, one-cycle latency.
    tick(1'b1, 1'b0, 1'b0, 32'd12, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Continuous contention: grants alternate, one result per cycle.
    drive(1'b1, 32'd5, 32'd10, 1'b1, 32'd89, 32'd120, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 32'd15, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'd209, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 32'd15, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'd209, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Back-pressure with a pending requester waiting behind the held result.
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd24567, 32'd4510, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 32'd29077, 1'b0);
    drive(1'b1, 32'd7, 32'd8, 1'b0, 32'd0, 32'd0, 1'b0);
    hold(32'd29077, 1'b1);
    req0_a = 32'd3;
    hold(32'd29077, 1'b1);
    req0_a = 32'd7;
    hold(32'd29077, 1'b1);
    rsp_ready = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 32'd15, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Wrap-around and carry.
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'd0, 1'b1);
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Asynchronous reset while holding a result with priority at 1.
    drive(1'b1, 32'd5, 32'd10, 1'b1, 32'd89, 32'd120, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 32'd15, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    hold(32'd15, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_data", 64'(rsp_data), 64'd0);
    sb.delete();
    drive(1'b1, 32'd5, 32'd10, 1'b1, 32'd89, 32'd120, 1'b1);
    #1;
    chk("async_rst_ready0", 64'(req0_ready), 64'd0);
    chk("async_rst_ready1", 64'(req1_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 32'd15, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'd209, 1'b0);

    // Fairness: uncontended grants leave priority alone, then 16 contended cycles.
    drive(1'b1, 32'd100, 32'd200, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'd300, 1'b0);
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
    drive(1'b1, 32'd3, 32'd4, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'd7, 1'b0);
    drive(1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 32'd1, 1'b1);
    drive(1'b1, 32'd5, 32'd10, 1'b1, 32'd89, 32'd120, 1'b1);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) tick(1'b1, 1'b0, 1'b1, 32'd15, 1'b0);
      else            tick(1'b0, 1'b1, 1'b1, 32'd209, 1'b0);
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
